// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a raw, bouncing push-button pad and
// releases a clean level only after it has held steady for a full window.
//
// Ports:
//   clk_i       single clock
//   reset_i     synchronous, active-high reset
//   btn_i       raw pad input (asynchronous, may bounce)
//   btn_o       debounced level, registered
//   settling_o  high while a candidate change is being timed
//
// Build option:
//   DEBOUNCE_ACTIVE_LOW_EN  invert btn_i ahead of the synchronizer so an
//                           active-low pad yields an active-high btn_o.
//                           Reset values stay in the post-inversion domain.

module button_debouncer #(
  parameter int   sync_stages_p   = 2,
  parameter int   stable_cycles_p = 48000,
  parameter int   count_width_p   = 16,
  parameter logic reset_val_p     = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic btn_o,
  output logic settling_o
);

  // Parameter legality, caught at elaboration.
  if (sync_stages_p < 2 || sync_stages_p > 4) begin : g_bad_sync
    $error("sync_stages_p must be in 2..4");
  end

  if (stable_cycles_p < 2) begin : g_bad_window
    $error("stable_cycles_p must be >= 2");
  end

  if (longint'(stable_cycles_p - 1) >=
      (longint'(1) << count_width_p)) begin : g_bad_width
    $error("stable_cycles_p-1 does not fit count_width_p");
  end

  localparam logic [0:0] STABLE   = 1'b0;
  localparam logic [0:0] SETTLING = 1'b1;

  localparam logic [count_width_p-1:0] last_count_c =
    count_width_p'(stable_cycles_p - 1);

  localparam logic [count_width_p-1:0] one_c =
    count_width_p'(1);

  // Pad polarity.
  logic pad_w;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  assign pad_w = ~btn_i;
`else
  assign pad_w = btn_i;
`endif

  // Synchronizer chain; only the last stage is seen downstream.
  logic [sync_stages_p-1:0] sync_q;
  logic                     sync_w;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {sync_stages_p{reset_val_p}};
    end else begin
      sync_q <= {sync_q[sync_stages_p-2:0], pad_w};
    end
  end

  assign sync_w = sync_q[sync_stages_p-1];

  // Settle FSM with stability counter.
  logic [0:0]               state_q;
  logic [0:0]               state_d;
  logic [count_width_p-1:0] count_q;
  logic [count_width_p-1:0] count_d;
  logic                     btn_q;
  logic                     btn_d;
  logic                     differs_w;
  logic                     window_done_w;

  assign differs_w     = (sync_w != btn_q);
  assign window_done_w = (count_q == last_count_c);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    btn_d   = btn_q;
    unique case (state_q)
      STABLE: begin
        count_d = '0;
        if (differs_w) begin
          state_d = SETTLING;
          count_d = one_c;
        end
      end
      SETTLING: begin
        if (!differs_w) begin
          // Bounced back to the current level: abandon the window.
          state_d = STABLE;
          count_d = '0;
        end else if (window_done_w) begin
          state_d = STABLE;
          count_d = '0;
          btn_d   = sync_w;
        end else begin
          count_d = count_q + one_c;
        end
      end
      default: begin
        state_d = STABLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= STABLE;
      count_q <= '0;
      btn_q   <= reset_val_p;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      btn_q   <= btn_d;
    end
  end

  assign btn_o      = btn_q;
  assign settling_o = (state_q == SETTLING);

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed per-cycle vectors feed a scoreboard queue;
// a negedge monitor pops and compares btn_o / settling_o.

module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset_i;
  logic btn_i;
  logic btn_o;
  logic settling_o;

  always #5 clk = ~clk;

  button_debouncer #(
    .sync_stages_p  (2),
    .stable_cycles_p(4),
    .count_width_p  (4),
    .reset_val_p    (1'b0)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .btn_i     (btn_i),
    .btn_o     (btn_o),
    .settling_o(settling_o)
  );

  typedef struct {
    int    edge_n;
    logic  eb;
    logic  es;
    string tag;
    int    idx;
  } exp_t;

  exp_t sb[$];
  int   edges = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) edges = edges + 1;

  function automatic logic bit_at(input string s, input int i);
    if (i >= s.len()) return 1'b0;
    return (s.getc(i) == 8'h31);
  endfunction

  // Monitor: checks each expectation right after its edge.
  exp_t e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].edge_n < edges) begin
      e = sb.pop_front();
      total = total + 1;
      bad = bad + 1;
      $display("FAIL %s[%0d] stale: edge %0d not checked (now %0d)",
               e.tag, e.idx, e.edge_n, edges);
    end
    if (sb.size() > 0 && sb[0].edge_n == edges) begin
      e = sb.pop_front();
      total = total + 1;
      if (btn_o !== e.eb) begin
        bad = bad + 1;
        $display("FAIL %s[%0d] btn_o: got %b want %b",
                 e.tag, e.idx, btn_o, e.eb);
      end
      total = total + 1;
      if (settling_o !== e.es) begin
        bad = bad + 1;
        $display("FAIL %s[%0d] settling_o: got %b want %b",
                 e.tag, e.idx, settling_o, e.es);
      end
    end
  end

  // Each character is one cycle: inputs driven before edge i+1,
  // expected outputs sampled after edge i+1.
  task automatic vec(input string tag, input string rst,
                     input string btn, input string eb,
                     input string es);
    exp_t x;
    for (int i = 0; i < btn.len(); i++) begin
      reset_i = bit_at(rst, i);
      btn_i   = bit_at(btn, i);
      x.edge_n = edges + 1;
      x.eb     = bit_at(eb, i);
      x.es     = bit_at(es, i);
      x.tag    = tag;
      x.idx    = i;
      sb.push_back(x);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_i = 1'b1;
    btn_i   = 1'b0;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
    vec("reset", "111", "000", "000", "000");
    vec("al_press", "", "0000000", "0000011", "0011100");
    vec("al_release", "", "1111111", "1111100", "0011100");
`else
    vec("reset",
        "111000000",
        "111100000",
        "000000000",
        "000001000");
    vec("press", "", "1111111", "0000011", "0011100");
    vec("release", "", "0000000", "1111100", "0011100");
    vec("bounce", "", "11000000", "00000000", "00110000");
    vec("bounce_settle", "",
        "101011111111",
        "000000000111",
        "001010111000");
    vec("release2", "", "0000000", "1111100", "0011100");
    vec("reset_mid",
        "000010000000",
        "111111111111",
        "000000000011",
        "001100011100");
`endif

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
